ex_cond_stage: RTL and testbench
================================

# ex_cond_stage

Execute-stage condition unit and EX/MEM pipeline register for the pipelined ARM core. It sits directly downstream of the ALU and consumes the ALU `Result` and its `ALUFlags` {N,Z,C,V}. It holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against it. It then gates the instruction's write/branch controls and registers everything into the memory stage.

## Interface
Parameters:
- `WIDTH`, 32: datapath width of the ALU result and store data.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low; 0 resets all state.
- `stall`  in  1: hold EX/MEM register and flags.
- `flush`  in  1: replace the instruction leaving E with a bubble.
- `CondE`  in  4: ARM condition field.
- `FlagWriteE`  in  2: [1] writes N,Z; [0] writes C,V.
- `ALUFlagsE`  in  4: from ALU; [3]=N, [2]=Z, [1]=C, [0]=V.
- `ALUResultE`  in  WIDTH: ALU result.
- `WriteDataE`  in  WIDTH: store data.
- `WA3E`  in  4: destination register.
- `RegWriteE`, `MemWriteE`, `MemtoRegE`, `PCSrcE`  in  1 each: ungated controls.
- `CondExE`  out  1: combinational condition-passed.
- `FlagsQ`  out  4: current NZCV register, same bit order as `ALUFlagsE`.
- `ALUResultM`, `WriteDataM`  out  WIDTH: registered data.
- `WA3M`  out  4: registered destination.
- `RegWriteM`, `MemWriteM`, `MemtoRegM`, `PCSrcM`  out  1: registered gated controls.

## Operation
- Condition evaluation is combinational from `FlagsQ`, never from `ALUFlagsE`. Codes:
  - EQ 0000: Z. NE 0001: ~Z. CS 0010: C. CC 0011: ~C.
  - MI 0100: N. PL 0101: ~N. VS 0110: V. VC 0111: ~V.
  - HI 1000: C&~Z. LS 1001: ~C|Z.
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: ~Z&(N==V). LE 1101: Z|(N!=V).
  - AL 1110: 1. Code 1111 evaluates to 0 (treated as a no-op).
- Flag update happens at the rising edge when `stall`=0, `flush`=0 and `CondExE`=1:
  - If `FlagWriteE[1]`, N,Z <= `ALUFlagsE[3:2]`.
  - If `FlagWriteE[0]`, C,V <= `ALUFlagsE[1:0]`.
  - Unwritten flag bits hold their value.
- Gating: `RegWriteM`, `MemWriteM` and `PCSrcM` capture the corresponding E control ANDed with `CondExE`. `MemtoRegM` captures `MemtoRegE` ungated.
- Data capture: `ALUResultM`, `WriteDataM` and `WA3M` capture their E inputs unconditionally when advancing, including when the condition fails.
- Priority at the edge: reset > stall > flush > normal advance.
  - `stall`=1: every register holds, including `FlagsQ`; `flush` is ignored.
  - `flush`=1 with `stall`=0: all M outputs load 0 and flags hold.
- Reset: `FlagsQ`=0000 and all M outputs 0, immediately on `reset` falling, independent of `clk`. The register clears even mid-stall.
- Width: no arithmetic in this block; data passes through unmodified.

## Timing
- E→M latency: 1 cycle.
- A flag write by instruction i is visible in `FlagsQ`, and so in `CondExE`, in the cycle after i leaves E. A compare followed immediately by a conditional instruction therefore works without a stall.
- `CondExE` settles within the cycle from `CondE` and `FlagsQ`; it has no dependence on `ALUFlagsE`.
- Deassertion of `reset` takes effect at the first rising `clk` edge after it returns to 1.

## Structure
- Shared package `cpu_pkg`:
  - `cond_t` enum of the 16 condition codes.
  - Flag index constants `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
  - `FW_NZ`=1 and `FW_CV`=0 bit indices for `FlagWriteE`.
- Sub-module `cond_check`: combinational (`CondE`, `FlagsQ`) → `CondExE`. It is reused by the single-cycle core.
- Top level: flag register, gating logic and EX/MEM register.

## Test plan
- **Reset:** drive non-zero M values, then pull `reset`=0 between edges. Required: all M outputs and `FlagsQ` read 0 before the next edge. With `CondE`=0000 after release, `CondExE`=0.
- **Compare then branch:**
  - Drive `ALUFlagsE`=0100, `FlagWriteE`=11, `CondE`=1110; after the edge `FlagsQ`=0100.
  - Next cycle, `CondE`=0000 with `PCSrcE`=1 and `RegWriteE`=1; after the edge `PCSrcM`=1 and `RegWriteM`=1.
  - Repeat with `CondE`=0001; after the edge both are 0.
- **Partial flag write:** with `FlagsQ`=0011, drive `ALUFlagsE`=1000 and `FlagWriteE`=10 under AL. Required: `FlagsQ`=1011.
- **Failed condition:** with `FlagsQ`=0000, drive `CondE`=0000, `FlagWriteE`=11, `ALUFlagsE`=0100, `MemWriteE`=1, `ALUResultE`=32'h1234. Required after the edge:
  - `FlagsQ`=0000 and `MemWriteM`=0.
  - `ALUResultM`=32'h1234.
- **Signed conditions:**
  - `FlagsQ`=1001 (N=1, V=1): GE=1, LT=0, GT=1, LE=0.
  - `FlagsQ`=1101: GT=0, LE=1.
  - `FlagsQ`=0010: HI=1, LS=0.
  - `CondE`=1111: `CondExE`=0 under any flags.
- **Stall and flush:**
  - `stall`=1 with new E inputs: M outputs and `FlagsQ` unchanged.
  - `flush`=1 with `stall`=0: all M outputs 0 and flags unchanged even with `FlagWriteE`=11.
  - `stall`=1 and `flush`=1 together: all registers hold.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the ARM core execute/condition logic.
//   cond_t     - 4-bit ARM condition field encodings
//   FLAG_*     - bit positions of N/Z/C/V in a 4-bit NZCV vector
//   FW_*       - bit positions in the 2-bit FlagWrite control
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// cond_check: combinational ARM condition evaluation.
//   CondE   in  4 : condition field
//   FlagsQ  in  4 : architectural NZCV ({N,Z,C,V})
//   CondExE out 1 : condition passed
// Shared with the single-cycle core, so keep it purely combinational.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] CondE,
  input  logic [3:0] FlagsQ,
  output logic       CondExE
);

  cond_t w_cond;
  logic  w_n, w_z, w_c, w_v, w_ge;

  assign w_cond = cond_t'(CondE);
  assign w_n    = FlagsQ[FLAG_N];
  assign w_z    = FlagsQ[FLAG_Z];
  assign w_c    = FlagsQ[FLAG_C];
  assign w_v    = FlagsQ[FLAG_V];
  assign w_ge   = (w_n == w_v);

  always_comb begin
    CondExE = 1'b0;
    case (w_cond)
      COND_EQ: CondExE = w_z;
      COND_NE: CondExE = ~w_z;
      COND_CS: CondExE = w_c;
      COND_CC: CondExE = ~w_c;
      COND_MI: CondExE = w_n;
      COND_PL: CondExE = ~w_n;
      COND_VS: CondExE = w_v;
      COND_VC: CondExE = ~w_v;
      COND_HI: CondExE = w_c & ~w_z;
      COND_LS: CondExE = ~w_c | w_z;
      COND_GE: CondExE = w_ge;
      COND_LT: CondExE = ~w_ge;
      COND_GT: CondExE = ~w_z & w_ge;
      COND_LE: CondExE = w_z | ~w_ge;
      COND_AL: CondExE = 1'b1;
      // 1111 is a no-op encoding in this core: never executes.
      default: CondExE = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_cond_stage.sv
// ex_cond_stage: execute-stage condition unit + EX/MEM pipeline register.
//   clk, reset(async, active low), stall, flush
//   CondE, FlagWriteE, ALUFlagsE          : condition / flag-update inputs
//   ALUResultE, WriteDataE, WA3E          : datapath captured into M
//   RegWriteE, MemWriteE, MemtoRegE, PCSrcE : ungated controls
//   CondExE  : combinational condition-passed (from FlagsQ only)
//   FlagsQ   : architectural NZCV register
//   *M       : registered data and gated controls
module ex_cond_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       ALUFlagsE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [3:0]       WA3E,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemtoRegE,
  input  logic             PCSrcE,
  output logic             CondExE,
  output logic [3:0]       FlagsQ,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [3:0]       WA3M,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM,
  output logic             PCSrcM
);

  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_alu_res, r_wdata;
  logic [3:0]       r_wa3;
  logic             r_rw, r_mw, r_m2r, r_pcs;
  logic             w_cond_ex, w_adv, w_fw_nz, w_fw_cv;

  cond_check u_cond (
    .CondE   (CondE),
    .FlagsQ  (r_flags),
    .CondExE (w_cond_ex)
  );

  // Stall outranks flush: a stalled instruction must not be squashed.
  assign w_adv   = ~stall & ~flush;
  assign w_fw_nz = w_adv & w_cond_ex & FlagWriteE[FW_NZ];
  assign w_fw_cv = w_adv & w_cond_ex & FlagWriteE[FW_CV];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else begin
      if (w_fw_nz) begin
        r_flags[FLAG_N] <= ALUFlagsE[FLAG_N];
        r_flags[FLAG_Z] <= ALUFlagsE[FLAG_Z];
      end
      if (w_fw_cv) begin
        r_flags[FLAG_C] <= ALUFlagsE[FLAG_C];
        r_flags[FLAG_V] <= ALUFlagsE[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu_res <= '0;
      r_wdata   <= '0;
      r_wa3     <= '0;
      r_rw      <= 1'b0;
      r_mw      <= 1'b0;
      r_m2r     <= 1'b0;
      r_pcs     <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        r_alu_res <= '0;
        r_wdata   <= '0;
        r_wa3     <= '0;
        r_rw      <= 1'b0;
        r_mw      <= 1'b0;
        r_m2r     <= 1'b0;
        r_pcs     <= 1'b0;
      end else begin
        // Data moves even on a failed condition; only side-effecting
        // controls are squashed. MemtoReg is harmless without RegWrite.
        r_alu_res <= ALUResultE;
        r_wdata   <= WriteDataE;
        r_wa3     <= WA3E;
        r_rw      <= RegWriteE & w_cond_ex;
        r_mw      <= MemWriteE & w_cond_ex;
        r_m2r     <= MemtoRegE;
        r_pcs     <= PCSrcE & w_cond_ex;
      end
    end
  end

  assign CondExE    = w_cond_ex;
  assign FlagsQ     = r_flags;
  assign ALUResultM = r_alu_res;
  assign WriteDataM = r_wdata;
  assign WA3M       = r_wa3;
  assign RegWriteM  = r_rw;
  assign MemWriteM  = r_mw;
  assign MemtoRegM  = r_m2r;
  assign PCSrcM     = r_pcs;

endmodule

// File: tb/tb_ex_cond_stage.sv
// Testbench for ex_cond_stage: scoreboard of expected M-stage/flag state,
// pushed when an edge is driven and popped after it.
module tb_ex_cond_stage;

  localparam int WIDTH = 32;

  logic             clk, reset, stall, flush;
  logic [3:0]       CondE, ALUFlagsE, WA3E;
  logic [1:0]       FlagWriteE;
  logic [WIDTH-1:0] ALUResultE, WriteDataE;
  logic             RegWriteE, MemWriteE, MemtoRegE, PCSrcE;
  logic             CondExE;
  logic [3:0]       FlagsQ, WA3M;
  logic [WIDTH-1:0] ALUResultM, WriteDataM;
  logic             RegWriteM, MemWriteM, MemtoRegM, PCSrcM;

  typedef struct packed {
    logic [3:0]       flags;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] wd;
    logic [3:0]       wa3;
    logic             rw, mw, m2r, pcs;
  } mst_t;

  mst_t m_st;          // model state
  mst_t sb[$];         // scoreboard
  int   checks = 0;
  int   errors = 0;

  ex_cond_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlagsE(ALUFlagsE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .PCSrcE(PCSrcE), .CondExE(CondExE), .FlagsQ(FlagsQ),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .PCSrcM(PCSrcM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;        4'h1: return !z;
      4'h2: return cy;       4'h3: return !cy;
      4'h4: return n;        4'h5: return !n;
      4'h6: return v;        4'h7: return !v;
      4'h8: return cy && !z; 4'h9: return !cy || z;
      4'hA: return n == v;   4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic mst_t observe();
    mst_t o;
    o.flags = FlagsQ;     o.res = ALUResultM; o.wd = WriteDataM;
    o.wa3   = WA3M;       o.rw  = RegWriteM;  o.mw = MemWriteM;
    o.m2r   = MemtoRegM;  o.pcs = PCSrcM;
    return o;
  endfunction

  // Advance the model by one edge using current inputs, queue the
  // expectation, and land 1 time unit after the edge.
  task automatic tick();
    mst_t n;
    logic ce;
    n  = m_st;
    ce = cond_ref(CondE, m_st.flags);
    if (!stall) begin
      if (flush) begin
        n.res = '0; n.wd = '0; n.wa3 = '0;
        n.rw = 0; n.mw = 0; n.m2r = 0; n.pcs = 0;
      end else begin
        if (ce && FlagWriteE[1]) n.flags[3:2] = ALUFlagsE[3:2];
        if (ce && FlagWriteE[0]) n.flags[1:0] = ALUFlagsE[1:0];
        n.res = ALUResultE; n.wd = WriteDataE; n.wa3 = WA3E;
        n.rw  = RegWriteE & ce; n.mw = MemWriteE & ce;
        n.m2r = MemtoRegE;      n.pcs = PCSrcE & ce;
      end
    end
    m_st = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; CondE = 4'hE; FlagWriteE = 2'b00; ALUFlagsE = 0;
    ALUResultE = 0; WriteDataE = 0; WA3E = 0;
    RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; PCSrcE = 0;
  endtask

  task automatic test_reset();
    mst_t e, g;
    reset = 0;
    idle_inputs();
    #2;
    g = observe(); checks++;
    if (g !== '0) begin errors++; $display("FAIL reset_init got=%h exp=0", g); end
    @(posedge clk); #1;
    reset = 1;
    m_st = '0;
    CondE = 4'hE; FlagWriteE = 2'b11; ALUFlagsE = 4'hF;
    ALUResultE = 32'hDEADBEEF; WriteDataE = 32'hCAFEF00D; WA3E = 4'h7;
    RegWriteE = 1; MemWriteE = 1; MemtoRegE = 1; PCSrcE = 1;
    tick();
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_preload got=%h exp=%h", g, e); end
    // Assert reset between edges, while stalled: must clear asynchronously.
    stall = 1;
    #2 reset = 0;
    #1;
    g = observe(); checks++;
    if (g !== '0) begin errors++; $display("FAIL reset_async got=%h exp=0", g); end
    m_st = '0;
    #1 reset = 1;
    idle_inputs();
    CondE = 4'h0;
    #1;
    checks++;
    if (CondExE !== 1'b0) begin errors++; $display("FAIL reset_condex got=%b exp=0", CondExE); end
    @(posedge clk); #1;
  endtask

  task automatic test_cmp_branch();
    mst_t e, g;
    idle_inputs();
    ALUFlagsE = 4'b0100; FlagWriteE = 2'b11; CondE = 4'hE;
    tick();
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e || FlagsQ !== 4'b0100) begin errors++; $display("FAIL cmp_flags got=%h exp=%h", g, e); end
    idle_inputs();
    CondE = 4'h0; PCSrcE = 1; RegWriteE = 1;
    tick();
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e || PCSrcM !== 1 || RegWriteM !== 1) begin errors++; $display("FAIL branch_eq got=%h exp=%h", g, e); end
    CondE = 4'h1;
    tick();
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e || PCSrcM !== 0 || RegWriteM !== 0) begin errors++; $display("FAIL branch_ne got=%h exp=%h", g, e); end
  endtask

  task automatic test_partial_flags();
    mst_t e, g;
    idle_inputs();
    ALUFlagsE = 4'b0011; FlagWriteE = 2'b11;
    tick();
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e) begin errors++; $display("FAIL partial_setup got=%h exp=%h", g, e); end
    ALUFlagsE = 4'b1000; FlagWriteE = 2'b10;
    tick();
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e || FlagsQ !== 4'b1011) begin errors++; $display("FAIL partial_nz got=%h exp=%h", g, e); end
  endtask

  task automatic test_failed_cond();
    mst_t e, g;
    idle_inputs();
    ALUFlagsE = 4'b0000; FlagWriteE = 2'b11;
    tick();
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e) begin errors++; $display("FAIL fail_setup got=%h exp=%h", g, e); end
    CondE = 4'h0; ALUFlagsE = 4'b0100; MemWriteE = 1; ALUResultE = 32'h1234;
    tick();
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e || FlagsQ !== 4'b0000 || MemWriteM !== 0 || ALUResultM !== 32'h1234) begin
      errors++; $display("FAIL fail_cond got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_signed_conds();
    mst_t e, g;
    logic [3:0] fv;
    for (int f = 0; f < 16; f++) begin
      idle_inputs();
      fv = f[3:0];
      ALUFlagsE = fv; FlagWriteE = 2'b11;
      tick();
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin errors++; $display("FAIL cond_setflags got=%h exp=%h", g, e); end
      stall = 1;   // hold state while probing the combinational output
      for (int c = 0; c < 16; c++) begin
        CondE = c[3:0];
        #0.5;
        checks++;
        if (CondExE !== cond_ref(c[3:0], fv)) begin
          errors++; $display("FAIL cond_%h_flags_%h got=%b exp=%b", c[3:0], fv, CondExE, cond_ref(c[3:0], fv));
        end
        if (fv == 4'b1001 && (c == 10 || c == 12)) begin
          checks++;
          if (CondExE !== 1'b1) begin errors++; $display("FAIL ge_gt_1001 got=%b exp=1", CondExE); end
        end
        if (fv == 4'b1101 && c == 12) begin
          checks++;
          if (CondExE !== 1'b0) begin errors++; $display("FAIL gt_1101 got=%b exp=0", CondExE); end
        end
        if (fv == 4'b0010 && c == 8) begin
          checks++;
          if (CondExE !== 1'b1) begin errors++; $display("FAIL hi_0010 got=%b exp=1", CondExE); end
        end
        if (c == 15) begin
          checks++;
          if (CondExE !== 1'b0) begin errors++; $display("FAIL nv_code got=%b exp=0", CondExE); end
        end
      end
      stall = 0;
      @(posedge clk); #1;
      // The stalled edge above leaves the model unchanged.
      g = observe(); checks++;
      if (g !== m_st) begin errors++; $display("FAIL cond_hold got=%h exp=%h", g, m_st); end
    end
  endtask

  task automatic test_stall_flush();
    mst_t e, g;
    idle_inputs();
    ALUResultE = 32'h55AA55AA; WriteDataE = 32'h0F0F0F0F; WA3E = 4'h3;
    RegWriteE = 1; MemtoRegE = 1; ALUFlagsE = 4'b0110; FlagWriteE = 2'b11;
    tick();
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e) begin errors++; $display("FAIL sf_setup got=%h exp=%h", g, e); end
    ALUResultE = 32'h11111111; WriteDataE = 32'h22222222; WA3E = 4'h9;
    ALUFlagsE = 4'b1001; MemWriteE = 1; PCSrcE = 1;
    stall = 1;
    tick();
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e || ALUResultM !== 32'h55AA55AA) begin errors++; $display("FAIL stall_hold got=%h exp=%h", g, e); end
    stall = 1; flush = 1;
    tick();
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e || WA3M !== 4'h3) begin errors++; $display("FAIL stall_flush_hold got=%h exp=%h", g, e); end
    stall = 0; flush = 1;
    tick();
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e || FlagsQ !== 4'b0110 || ALUResultM !== '0) begin errors++; $display("FAIL flush got=%h exp=%h", g, e); end
  endtask

  task automatic test_back_to_back();
    mst_t e, g;
    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      CondE = 4'($urandom); FlagWriteE = 2'($urandom); ALUFlagsE = 4'($urandom);
      ALUResultE = $urandom; WriteDataE = $urandom; WA3E = 4'($urandom);
      RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
      MemtoRegE = 1'($urandom); PCSrcE = 1'($urandom);
      #0.5;
      checks++;
      if (CondExE !== cond_ref(CondE, m_st.flags)) begin
        errors++; $display("FAIL b2b_condex got=%b exp=%b", CondExE, cond_ref(CondE, m_st.flags));
      end
      tick();
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_cycle%0d got=%h exp=%h", i, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_cmp_branch();
    test_partial_flags();
    test_failed_cond();
    test_signed_conds();
    test_stall_flush();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
